demux2x_tuple_bit_bits_reg: RTL and testbench

//  Registered 1-to-2 stream demultiplexer for a flattened tuple (Bit, Bits[WIDTH]).
//  It is the fan-out counterpart of the 2-to-1 tuple mux.

---
 rtl/demux2x_tuple_bit_bits_reg_if.sv | 31 +++
 rtl/demux2x_tuple_bit_bits_reg.sv | 104 ++++++++++
 tb/tb_demux2x_tuple_bit_bits_reg.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/demux2x_tuple_bit_bits_reg_if.sv
// Stream bundle for the registered 1-to-2 tuple demux: one (Bit, Bits[WIDTH]) input
// stream with a destination select, and two output streams.
interface demux2x_tuple_bit_bits_reg_if #(
  parameter int WIDTH = 2
);
  logic             I__0;
  logic [WIDTH-1:0] I__1;
  logic             S;
  logic             I_valid;
  logic             I_ready;
  logic             O0__0;
  logic [WIDTH-1:0] O0__1;
  logic             O0_valid;
  logic             O0_ready;
  logic             O1__0;
  logic [WIDTH-1:0] O1__1;
  logic             O1_valid;
  logic             O1_ready;

  // Block side.
  modport slave (
    input  I__0, I__1, S, I_valid, O0_ready, O1_ready,
    output I_ready, O0__0, O0__1, O0_valid, O1__0, O1__1, O1_valid
  );

  // Producer/consumer side.
  modport master (
    output I__0, I__1, S, I_valid, O0_ready, O1_ready,
    input  I_ready, O0__0, O0__1, O0_valid, O1__0, O1__1, O1_valid
  );
endinterface

// File: rtl/demux2x_tuple_bit_bits_reg.sv
// Registered 1-to-2 tuple demux: S steers each accepted transfer into one of two
// single-entry holding registers that drain independently.
module demux2x_tuple_chan #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             ready,
  output logic             valid,
  output logic             drain,
  output logic             q0,
  output logic [WIDTH-1:0] q1
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             f0_q, f0_d;
  logic [WIDTH-1:0] f1_q, f1_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      f0_q    <= 1'b0;
      f1_q    <= '0;
    end else begin
      state_q <= state_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    f0_d    = f0_q;
    f1_d    = f1_q;
    drain   = (state_q == FULL) & ready;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (drain && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    // load is only raised when the slot is empty or draining this cycle
    if (load) begin
      f0_d = d0;
      f1_d = d1;
    end
  end

  assign valid = (state_q == FULL);
  assign q0    = f0_q;
  assign q1    = f1_q;
endmodule

module demux2x_tuple_bit_bits_reg #(
  parameter int WIDTH = 2
) (
  input  logic                         CLK,
  input  logic                         ASYNCRESETN,
  demux2x_tuple_bit_bits_reg_if.slave  io
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]            ch_load, ch_ready, ch_valid, ch_drain, ch_f0;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_f1;
  logic                         i_ready, accept;

  assign ch_ready = {io.O1_ready, io.O0_ready};

  // Back-pressure looks only at the selected channel, so a stalled channel
  // never blocks traffic headed for the other one.
  always_comb begin
    i_ready    = ASYNCRESETN & (~ch_valid[io.S] | ch_drain[io.S]);
    accept     = io.I_valid & i_ready;
    ch_load    = '0;
    ch_load[0] = accept & ~io.S;
    ch_load[1] = accept &  io.S;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux2x_tuple_chan #(.WIDTH(WIDTH)) u_chan (
      .clk   (CLK),
      .rst_n (ASYNCRESETN),
      .load  (ch_load[k]),
      .d0    (io.I__0),
      .d1    (io.I__1),
      .ready (ch_ready[k]),
      .valid (ch_valid[k]),
      .drain (ch_drain[k]),
      .q0    (ch_f0[k]),
      .q1    (ch_f1[k])
    );
  end

  assign io.I_ready  = i_ready;
  assign io.O0_valid = ch_valid[0];
  assign io.O0__0    = ch_f0[0];
  assign io.O0__1    = ch_f1[0];
  assign io.O1_valid = ch_valid[1];
  assign io.O1__0    = ch_f0[1];
  assign io.O1__1    = ch_f1[1];
endmodule

// File: tb/tb_demux2x_tuple_bit_bits_reg.sv
// Randomized + directed bench for the registered tuple demux, checked every cycle
// against a per-channel queue model.
module tb_demux2x_tuple_bit_bits_reg;
  localparam int W = 2;

  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  always #5 CLK = ~CLK;

  demux2x_tuple_bit_bits_reg_if #(.WIDTH(W)) bus ();

  demux2x_tuple_bit_bits_reg #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .io          (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: each channel is a FIFO of capacity one; output shows its head.
  logic [W:0] mq0[$];
  logic [W:0] mq1[$];
  logic       hold_in = 1'b0;

  always @(negedge CLK) begin
    bit f0, f1, exp_ir, acc;
    if (!ASYNCRESETN) begin
      chk("rst_iready", bus.I_ready, 0);
      chk("rst_o0v", bus.O0_valid, 0);
      chk("rst_o1v", bus.O1_valid, 0);
      mq0.delete();
      mq1.delete();
      hold_in = 1'b0;
    end else begin
      f0 = (mq0.size() != 0);
      f1 = (mq1.size() != 0);
      chk("o0_valid", bus.O0_valid, f0);
      chk("o1_valid", bus.O1_valid, f1);
      if (f0) chk("o0_data", {bus.O0__0, bus.O0__1}, mq0[0]);
      if (f1) chk("o1_data", {bus.O1__0, bus.O1__1}, mq1[0]);
      exp_ir = bus.S ? (!f1 || bus.O1_ready) : (!f0 || bus.O0_ready);
      chk("i_ready", bus.I_ready, exp_ir);
      acc = bus.I_valid && exp_ir;
      if (f0 && bus.O0_ready) void'(mq0.pop_front());
      if (f1 && bus.O1_ready) void'(mq1.pop_front());
      if (acc) begin
        if (bus.S) mq1.push_back({bus.I__0, bus.I__1});
        else       mq0.push_back({bus.I__0, bus.I__1});
      end
      hold_in = bus.I_valid && !exp_ir;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic s, input logic f0, input logic [W-1:0] f1);
    bus.I_valid = 1'b1;
    bus.S       = s;
    bus.I__0    = f0;
    bus.I__1    = f1;
  endtask

  initial begin
    logic [W:0] item;
    bus.I_valid  = 1'b1;
    bus.S        = 1'b0;
    bus.I__0     = 1'b1;
    bus.I__1     = 2'b11;
    bus.O0_ready = 1'b1;
    bus.O1_ready = 1'b1;

    // Reset held with a valid input pending
    repeat (3) step();
    chk("t1_o0v", bus.O0_valid, 0);
    chk("t1_o1v", bus.O1_valid, 0);
    chk("t1_iready", bus.I_ready, 0);
    bus.I_valid = 1'b0;
    ASYNCRESETN = 1'b1;
    #1;
    chk("t1_iready_rel", bus.I_ready, 1);

    // Route to each channel
    send(1'b0, 1'b1, 2'b10);
    step();
    chk("t2_o0v", bus.O0_valid, 1);
    chk("t2_o0", {bus.O0__0, bus.O0__1}, 3'b110);
    chk("t2_o1v", bus.O1_valid, 0);
    send(1'b1, 1'b0, 2'b01);
    step();
    chk("t2_o1v2", bus.O1_valid, 1);
    chk("t2_o1", {bus.O1__0, bus.O1__1}, 3'b001);
    chk("t2_o0v2", bus.O0_valid, 0);
    bus.I_valid = 1'b0;
    step();

    // Stall channel 0
    bus.O0_ready = 1'b0;
    send(1'b0, 1'b1, 2'b11);
    step();
    send(1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_iready_stall", bus.I_ready, 0);
      chk("t3_o0_hold", {bus.O0_valid, bus.O0__0, bus.O0__1}, 4'b1111);
      step();
    end
    bus.O0_ready = 1'b1;
    #1;
    chk("t3_iready_drain", bus.I_ready, 1);
    step();
    chk("t3_o0_new", {bus.O0_valid, bus.O0__0, bus.O0__1}, 4'b1000);

    // Channel 0 stalled, channel 1 still flows
    bus.O0_ready = 1'b0;
    send(1'b1, 1'b0, 2'b10);
    #1;
    chk("t4_iready", bus.I_ready, 1);
    step();
    chk("t4_o1", {bus.O1_valid, bus.O1__0, bus.O1__1}, 4'b1010);
    chk("t4_o0", {bus.O0_valid, bus.O0__0, bus.O0__1}, 4'b1000);
    bus.I_valid  = 1'b0;
    bus.O0_ready = 1'b1;
    step();

    // Back-to-back throughput on channel 0
    for (int i = 0; i < 8; i++) begin
      item = 3'(i);
      send(1'b0, item[2], item[1:0]);
      #1;
      chk("t5_iready", bus.I_ready, 1);
      step();
      chk("t5_o0", {bus.O0_valid, bus.O0__0, bus.O0__1}, {1'b1, item});
    end
    bus.I_valid = 1'b0;
    step();

    // Asynchronous reset with both channels full
    bus.O0_ready = 1'b0;
    bus.O1_ready = 1'b0;
    send(1'b0, 1'b1, 2'b01);
    step();
    send(1'b1, 1'b1, 2'b10);
    step();
    bus.I_valid = 1'b0;
    chk("t6_full", {bus.O0_valid, bus.O1_valid}, 2'b11);
    #1;
    ASYNCRESETN = 1'b0;
    #1;
    chk("t6_async_v", {bus.O0_valid, bus.O1_valid}, 2'b00);
    chk("t6_async_d", {bus.O0__0, bus.O0__1, bus.O1__0, bus.O1__1}, 6'b0);
    step();
    ASYNCRESETN = 1'b1;
    step();
    step();
    chk("t6_after", {bus.O0_valid, bus.O1_valid}, 2'b00);

    // Random traffic; producer holds a stalled transfer
    for (int c = 0; c < 3000; c++) begin
      if (!hold_in) begin
        bus.I_valid = ($urandom_range(0, 9) < 7);
        bus.S       = 1'($urandom);
        bus.I__0    = 1'($urandom);
        bus.I__1    = W'($urandom);
      end
      bus.O0_ready = ($urandom_range(0, 3) != 0);
      bus.O1_ready = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
